// File: rtl/alu_arbiter_seq.sv
// Round-robin arbiter between two ALU requesters plus a multi-pass sequencer
// that feeds each registered ALU result back as the next operand.
module alu_arbiter_seq #(
  parameter int W  = 8,
  parameter int IW = 9,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_valid_i,
  input  logic [IW-1:0] a_instr_i,
  input  logic [W-1:0]  a_data_i,
  input  logic [CW-1:0] a_count_i,
  output logic          a_ready_o,
  output logic          a_done_o,
  input  logic          b_valid_i,
  input  logic [IW-1:0] b_instr_i,
  input  logic [W-1:0]  b_data_i,
  input  logic [CW-1:0] b_count_i,
  output logic          b_ready_o,
  output logic          b_done_o,
  output logic [W-1:0]  result_o,
  output logic          overflow_o,
  output logic          busy_o,
  output logic [IW-1:0] alu_instr_o,
  output logic [W-1:0]  alu_data_o,
  input  logic [W-1:0]  alu_result_i,
  input  logic          alu_ovf_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          ptr_b;
  logic          owner_b;
  logic [IW-1:0] instr_r;
  logic [W-1:0]  op_r;
  logic [CW-1:0] remain;
  logic          ovf_r;
  logic          grant_a, grant_b, accept;

  assign grant_a = a_valid_i && (!ptr_b || !b_valid_i);
  assign grant_b = b_valid_i && ( ptr_b || !a_valid_i);
  assign accept  = (state == IDLE) && (grant_a || grant_b);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (remain == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_b      <= 1'b0;
      owner_b    <= 1'b0;
      instr_r    <= '0;
      op_r       <= '0;
      remain     <= '0;
      ovf_r      <= 1'b0;
      result_o   <= '0;
      overflow_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            instr_r <= grant_a ? a_instr_i : b_instr_i;
            op_r    <= grant_a ? a_data_i  : b_data_i;
            remain  <= grant_a ? a_count_i : b_count_i;
            owner_b <= !grant_a;
            ptr_b   <= grant_a;
            ovf_r   <= 1'b0;
          end
        end
        RUN: begin
          op_r  <= alu_result_i;
          ovf_r <= ovf_r | alu_ovf_i;
          // Final pass loads the outputs directly so they are valid alongside the done pulse.
          if (remain == '0) begin
            result_o   <= alu_result_i;
            overflow_o <= ovf_r | alu_ovf_i;
          end else begin
            remain <= remain - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    a_ready_o   = 1'b0;
    b_ready_o   = 1'b0;
    a_done_o    = 1'b0;
    b_done_o    = 1'b0;
    busy_o      = (state != IDLE);
    alu_instr_o = '0;
    alu_data_o  = '0;
    case (state)
      IDLE: begin
        a_ready_o = grant_a;
        b_ready_o = grant_b;
      end
      RUN: begin
        alu_instr_o = instr_r;
        alu_data_o  = op_r;
      end
      DONE: begin
        a_done_o = !owner_b;
        b_done_o =  owner_b;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_arbiter_seq.sv
// Directed bench for alu_arbiter_seq with a small combinational ALU model.
module tb_alu_arbiter_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_valid_i, b_valid_i;
  logic [8:0] a_instr_i, b_instr_i;
  logic [7:0] a_data_i, b_data_i;
  logic [2:0] a_count_i, b_count_i;
  logic       a_ready_o, a_done_o, b_ready_o, b_done_o;
  logic [7:0] result_o;
  logic       overflow_o, busy_o;
  logic [8:0] alu_instr_o;
  logic [7:0] alu_data_o;
  logic [7:0] alu_result_i;
  logic       alu_ovf_i;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  alu_arbiter_seq #(.W(8), .IW(9), .CW(3)) dut (
    .clk(clk), .reset(reset),
    .a_valid_i(a_valid_i), .a_instr_i(a_instr_i), .a_data_i(a_data_i),
    .a_count_i(a_count_i), .a_ready_o(a_ready_o), .a_done_o(a_done_o),
    .b_valid_i(b_valid_i), .b_instr_i(b_instr_i), .b_data_i(b_data_i),
    .b_count_i(b_count_i), .b_ready_o(b_ready_o), .b_done_o(b_done_o),
    .result_o(result_o), .overflow_o(overflow_o), .busy_o(busy_o),
    .alu_instr_o(alu_instr_o), .alu_data_o(alu_data_o),
    .alu_result_i(alu_result_i), .alu_ovf_i(alu_ovf_i)
  );

  always #5 clk = ~clk;

  // ALU model: 1 = increment, 2 = shift-left-1 (ovf = carry out),
  // 3 = increment with ovf only when the operand is 0x11
  always_comb begin
    alu_result_i = 8'h00;
    alu_ovf_i    = 1'b0;
    case (alu_instr_o)
      9'd1: {alu_ovf_i, alu_result_i} = {1'b0, alu_data_o} + 9'd1;
      9'd2: {alu_ovf_i, alu_result_i} = {alu_data_o, 1'b0};
      9'd3: begin
        alu_result_i = alu_data_o + 8'd1;
        alu_ovf_i    = (alu_data_o == 8'h11);
      end
      default: ;
    endcase
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    a_valid_i = 1'b0; a_instr_i = '0; a_data_i = '0; a_count_i = '0;
    b_valid_i = 1'b0; b_instr_i = '0; b_data_i = '0; b_count_i = '0;
    tick; tick;
    chk("rst_busy", busy_o, 0);
    chk("rst_a_ready", a_ready_o, 0);
    chk("rst_b_ready", b_ready_o, 0);
    chk("rst_a_done", a_done_o, 0);
    chk("rst_b_done", b_done_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_alu_instr", alu_instr_o, 0);
    chk("rst_alu_data", alu_data_o, 0);
    reset = 1'b0;
    tick;

    // Single A request, one pass of increment
    a_valid_i = 1'b1; a_instr_i = 9'd1; a_data_i = 8'h05; a_count_i = 3'd0;
    #1;
    chk("t1_a_ready", a_ready_o, 1);
    chk("t1_b_ready", b_ready_o, 0);
    tick;
    a_valid_i = 1'b0;
    chk("t1_busy", busy_o, 1);
    chk("t1_alu_instr", alu_instr_o, 1);
    chk("t1_alu_data", alu_data_o, 8'h05);
    chk("t1_no_ready", a_ready_o, 0);
    tick;
    chk("t1_a_done", a_done_o, 1);
    chk("t1_b_done", b_done_o, 0);
    chk("t1_result", result_o, 8'h06);
    chk("t1_ovf", overflow_o, 0);
    chk("t1_alu_idle", alu_data_o, 0);
    tick;
    chk("t1_done_low", a_done_o, 0);
    chk("t1_idle", busy_o, 0);
    chk("t1_hold", result_o, 8'h06);

    // B request, eight shift passes
    b_valid_i = 1'b1; b_instr_i = 9'd2; b_data_i = 8'h01; b_count_i = 3'd7;
    #1;
    chk("t2_b_ready", b_ready_o, 1);
    tick;
    b_valid_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t2_alu_data", alu_data_o, 32'h1 << i);
      chk("t2_b_done_early", b_done_o, 0);
      tick;
    end
    chk("t2_b_done", b_done_o, 1);
    chk("t2_a_done", a_done_o, 0);
    chk("t2_result", result_o, 8'h00);
    chk("t2_ovf", overflow_o, 1);
    tick;
    chk("t2_done_low", b_done_o, 0);
    chk("t2_idle", busy_o, 0);

    // Sticky overflow: only the second of three passes overflows
    a_valid_i = 1'b1; a_instr_i = 9'd3; a_data_i = 8'h10; a_count_i = 3'd2;
    #1;
    chk("t3_a_ready", a_ready_o, 1);
    tick;
    a_valid_i = 1'b0;
    b_valid_i = 1'b1; b_instr_i = 9'd1; b_data_i = 8'hAA; b_count_i = 3'd0;
    #1;
    chk("t3_b_ignored", b_ready_o, 0);
    tick;
    b_valid_i = 1'b0;
    tick;
    tick;
    chk("t3_a_done", a_done_o, 1);
    chk("t3_result", result_o, 8'h13);
    chk("t3_ovf", overflow_o, 1);
    tick;

    // Following request with no overflow clears the flag
    a_valid_i = 1'b1; a_instr_i = 9'd1; a_data_i = 8'h20; a_count_i = 3'd1;
    #1;
    chk("t4_a_ready", a_ready_o, 1);
    tick;
    a_valid_i = 1'b0;
    tick;
    tick;
    chk("t4_a_done", a_done_o, 1);
    chk("t4_result", result_o, 8'h22);
    chk("t4_ovf", overflow_o, 0);
    tick;

    // Reset on the third RUN cycle drops the request
    a_valid_i = 1'b1; a_instr_i = 9'd1; a_data_i = 8'h00; a_count_i = 3'd5;
    #1;
    chk("t5_a_ready", a_ready_o, 1);
    tick;
    a_valid_i = 1'b0;
    tick;
    tick;
    chk("t5_run3_data", alu_data_o, 8'h02);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("t5_busy", busy_o, 0);
    chk("t5_a_done", a_done_o, 0);
    chk("t5_result", result_o, 0);
    chk("t5_ovf", overflow_o, 0);
    chk("t5_alu_data", alu_data_o, 0);

    // Continuous contention after reset: A, B, A, B
    a_valid_i = 1'b1; a_instr_i = 9'd1; a_data_i = 8'h40; a_count_i = 3'd0;
    b_valid_i = 1'b1; b_instr_i = 9'd1; b_data_i = 8'h50; b_count_i = 3'd0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t6_a_ready", a_ready_o, (k % 2 == 0) ? 1 : 0);
      chk("t6_b_ready", b_ready_o, (k % 2 == 0) ? 0 : 1);
      tick;
      chk("t6_run_ready", a_ready_o | b_ready_o, 0);
      chk("t6_alu_data", alu_data_o, (k % 2 == 0) ? 8'h40 : 8'h50);
      tick;
      chk("t6_a_done", a_done_o, (k % 2 == 0) ? 1 : 0);
      chk("t6_b_done", b_done_o, (k % 2 == 0) ? 0 : 1);
      chk("t6_result", result_o, (k % 2 == 0) ? 8'h41 : 8'h51);
      tick;
    end
    a_valid_i = 1'b0;
    b_valid_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter_seq.md
# alu_arbiter_seq

Two-requester arbiter and multi-pass sequencer for the shared combinational ALU. It accepts 9-bit ALU instructions from the core datapath (port A) and the LUT/debug loader (port B), and grants the ALU to one of them round-robin. It issues each accepted instruction to the ALU for 1–8 consecutive passes, feeding each registered result back as the next operand. It returns the final result and a sticky overflow flag with a one-cycle done pulse.

## Interface
Parameters:
- W, 8, operand/result width (ALU data width)
- IW, 9, instruction width (ALU opcode field)
- CW, 3, pass-count width; passes = count + 1 (1..8)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- a_valid_i  in  1  port A request valid
- a_instr_i  in  IW  port A ALU instruction
- a_data_i  in  W  port A initial operand
- a_count_i  in  CW  port A extra passes
- a_ready_o  out  1  port A request accepted this cycle
- a_done_o  out  1  one-cycle pulse: port A result valid
- b_valid_i, b_instr_i, b_data_i, b_count_i, b_ready_o, b_done_o  same as port A, for port B
- result_o  out  W  final result of the most recent completed request
- overflow_o  out  1  OR of ALU overflow over all passes of that request
- busy_o  out  1  high whenever state is not IDLE
- alu_instr_o  out  IW  instruction driven to the ALU
- alu_data_o  out  W  operand driven to the ALU
- alu_result_i  in  W  ALU combinational result
- alu_ovf_i  in  1  ALU combinational overflow

## Operation
- States: IDLE, RUN, DONE. Reset: IDLE.
- Reset values: a/b_ready_o=0, a/b_done_o=0, result_o=0, overflow_o=0, busy_o=0, alu_instr_o=0, alu_data_o=0, priority pointer=A.
- Arbitration (IDLE only): grant A if a_valid_i and (pointer=A or !b_valid_i); grant B if b_valid_i and (pointer=B or !a_valid_i). Ready is combinational: x_ready_o = IDLE and grant=x. At most one ready is high in any cycle. No ready outside IDLE.
- Accept (valid and ready): latch instr, data, and count into the operand register. Record the owner. Load remaining = count. Clear sticky ovf. Set pointer to the non-granted port. Go to RUN.
- RUN: alu_instr_o = latched instr, alu_data_o = operand register. Each cycle: operand register <= alu_result_i; sticky ovf |= alu_ovf_i. If remaining=0, go to DONE; else remaining decrements.
- DONE: result_o <= operand register, overflow_o <= sticky ovf, owner's done pulses high for exactly this cycle. Next state is IDLE.
- Outside RUN, alu_instr_o=0 and alu_data_o=0 (opcode 0 is benign).
- result_o/overflow_o hold until the next DONE. No wrap on count: count=7 means 8 passes.
- A requester deasserting valid without a ready: no effect. Inputs are ignored while not in IDLE.

## Timing
- Accept at edge T (cycle with valid and ready). RUN spans cycles T+1 .. T+1+count. DONE is cycle T+2+count. IDLE is at T+3+count.
- Latency accept-to-done = count + 2 cycles. Throughput: one request per count+3 cycles.
- Simultaneous requests in IDLE: pointer decides. Back-to-back contention strictly alternates A,B,A,B.
- A new request may be accepted in the IDLE cycle right after DONE.
- Reset asserted in any state: next cycle is IDLE with all reset values. An in-flight request is dropped with no done pulse. The pointer returns to A.

## Test plan
- Single A request: instr=1, data=0x05, count=0, ALU model adds 1 -> a_ready_o at T, alu_data_o=0x05 at T+1, a_done_o at T+2, result_o=0x06, overflow_o=0.
- Multi-pass: B instr=shift-left-1, data=0x01, count=7 -> 8 RUN cycles; alu_data_o sequence 0x01,0x02,...,0x80. b_done_o at T+9, result_o=0x00, overflow_o=1 (last pass carries out).
- Contention: A and B valid continuously after reset, count=0 -> grants A,B,A,B. Done pulses every 3 cycles on the alternating port. Never both readies high.
- Sticky overflow: count=2, ALU model asserts ovf only on pass 2 -> overflow_o=1 at done. A following request with no ovf -> overflow_o=0.
- Reset mid-RUN: A accepted with count=5, reset asserted on 3rd RUN cycle -> next cycle IDLE, busy_o=0, no a_done_o, result_o=0. Then simultaneous A/B requests -> A granted first.
